// File: rtl/countdown_timer_pkg.sv
// Shared types and constants for the countdown timer: FSM states, the BCD
// digit type and the digit limits used by the time counters.
package countdown_timer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ALARM = 2'd3
   } state_e;

   typedef logic [3:0] bcd_t;

   localparam bcd_t       SEC_TENS_MAX = 4'd5;
   localparam bcd_t       DIGIT_MAX    = 4'd9;
   localparam logic [6:0] MIN_MAX      = 7'd99;

   // Split a two-digit decimal limit into its tens digit.
   function automatic bcd_t tens_of(input logic [6:0] val);
      return 4'(val / 7'd10);
   endfunction

   // Split a two-digit decimal limit into its ones digit.
   function automatic bcd_t ones_of(input logic [6:0] val);
      return 4'(val % 7'd10);
   endfunction

endpackage

// File: rtl/countdown_timer_bcd_digit_counter.sv
// One BCD digit with increment/decrement enables, a run-time maximum and
// combinational carry/borrow outputs for chaining into the next digit.
module bcd_digit_counter
   import countdown_timer_pkg::*;
(
   input  logic clk,
   input  logic reset,
   input  logic clr,
   input  logic inc,
   input  logic dec,
   input  bcd_t max_val,
   output bcd_t value,
   output logic carry,
   output logic borrow
);

   bcd_t value_d;
   bcd_t value_q;

   // Next digit value; clear wins over inc, inc over dec.
   always_comb begin
      carry  = inc && (value_q == max_val);
      borrow = dec && (value_q == 4'd0);
      if (clr) begin
         value_d = 4'd0;
      end else if (inc) begin
         value_d = carry ? 4'd0 : value_q + 4'd1;
      end else if (dec) begin
         value_d = borrow ? max_val : value_q - 4'd1;
      end else begin
         value_d = value_q;
      end
   end

   // Digit register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         value_q <= 4'd0;
      end else begin
         value_q <= value_d;
      end
   end

   assign value = value_q;

endmodule

// File: rtl/countdown_timer.sv
// MM:SS countdown timer with IDLE/RUN/PAUSE/ALARM control and tick prescaler.
// Define TIMER_ALARM_BLINK_EN to make the alarm output blink while in ALARM.
module countdown_timer
   import countdown_timer_pkg::*;
#(
   parameter int unsigned TICKS_PER_SEC = 10,
   parameter int unsigned ALARM_SECS    = 30
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic start,
   input  logic pause,
   input  logic clear,
   input  logic inc_min,
   input  logic inc_sec,
   output bcd_t min_tens,
   output bcd_t min_ones,
   output bcd_t sec_tens,
   output bcd_t sec_ones,
   output logic running,
   output logic alarm
);

   localparam logic [7:0]  PRESC_RELOAD = 8'(TICKS_PER_SEC - 1);
   localparam logic [15:0] ALARM_LAST   = 16'(ALARM_SECS - 1);

   state_e      state_d, state_q;
   logic [7:0]  presc_d, presc_q;
   logic [15:0] asec_d, asec_q;
   logic        running_d, running_q;
   logic        alarm_d, alarm_q;
   logic        dig_clr, sec_inc, min_inc, sec_dec;
   logic        so_carry, so_borrow, st_borrow, mo_carry, mo_borrow;
   logic        unused_st_carry, unused_mt_carry, unused_mt_borrow;
   logic        time_nz, time_one;

`ifdef TIMER_ALARM_BLINK_EN
   localparam int unsigned BLINK_HALF = (TICKS_PER_SEC / 2 < 1) ? 1 : TICKS_PER_SEC / 2;
   localparam logic [7:0]  BLINK_LAST = 8'(BLINK_HALF - 1);
   logic [7:0] blink_cnt_d, blink_cnt_q;
`endif

   assign time_nz  = |{min_tens, min_ones, sec_tens, sec_ones};
   assign time_one = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);

   // Control FSM: command priority clear > pause > start > inc, then tick handling.
   always_comb begin
      state_d = state_q;
      presc_d = presc_q;
      asec_d  = asec_q;
      dig_clr = 1'b0;
      sec_inc = 1'b0;
      min_inc = 1'b0;
      sec_dec = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (clear) begin
               dig_clr = 1'b1;
               presc_d = PRESC_RELOAD;
            end else if (pause) begin
               state_d = ST_IDLE;
            end else if (start) begin
               if (time_nz) begin
                  state_d = ST_RUN;
                  presc_d = PRESC_RELOAD;
               end else begin
                  state_d = ST_IDLE;
               end
            end else begin
               sec_inc = inc_sec;
               min_inc = inc_min;
            end
         end
         ST_RUN: begin
            if (clear) begin
               state_d = ST_IDLE;
               dig_clr = 1'b1;
               presc_d = PRESC_RELOAD;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (tick) begin
               if (presc_q == 8'd0) begin
                  presc_d = PRESC_RELOAD;
                  sec_dec = 1'b1;
                  state_d = time_one ? ST_ALARM : ST_RUN;
               end else begin
                  presc_d = presc_q - 8'd1;
               end
            end else begin
               state_d = ST_RUN;
            end
         end
         ST_PAUSE: begin
            if (clear) begin
               state_d = ST_IDLE;
               dig_clr = 1'b1;
               presc_d = PRESC_RELOAD;
            end else if (pause) begin
               state_d = ST_PAUSE;
            end else if (start) begin
               state_d = ST_RUN;
            end else begin
               state_d = ST_PAUSE;
            end
         end
         ST_ALARM: begin
            // A pause pulse outranks start, so start+pause is not an acknowledge.
            if (clear || (start && !pause)) begin
               state_d = ST_IDLE;
               dig_clr = 1'b1;
               presc_d = PRESC_RELOAD;
               asec_d  = 16'd0;
            end else if (tick) begin
               if (presc_q == 8'd0) begin
                  presc_d = PRESC_RELOAD;
                  if (asec_q == ALARM_LAST) begin
                     state_d = ST_IDLE;
                     dig_clr = 1'b1;
                     asec_d  = 16'd0;
                  end else begin
                     asec_d = asec_q + 16'd1;
                  end
               end else begin
                  presc_d = presc_q - 8'd1;
               end
            end else begin
               state_d = ST_ALARM;
            end
         end
         default: begin
            state_d = ST_IDLE;
            dig_clr = 1'b1;
            presc_d = PRESC_RELOAD;
            asec_d  = 16'd0;
         end
      endcase

      running_d = (state_d == ST_RUN);
`ifdef TIMER_ALARM_BLINK_EN
      blink_cnt_d = blink_cnt_q;
      if (state_d != ST_ALARM) begin
         alarm_d     = 1'b0;
         blink_cnt_d = 8'd0;
      end else if (state_q != ST_ALARM) begin
         alarm_d     = 1'b1;
         blink_cnt_d = 8'd0;
      end else if (tick) begin
         if (blink_cnt_q == BLINK_LAST) begin
            alarm_d     = ~alarm_q;
            blink_cnt_d = 8'd0;
         end else begin
            alarm_d     = alarm_q;
            blink_cnt_d = blink_cnt_q + 8'd1;
         end
      end else begin
         alarm_d = alarm_q;
      end
`else
      alarm_d = (state_d == ST_ALARM);
`endif
   end

   // Control and output registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= ST_IDLE;
         presc_q   <= PRESC_RELOAD;
         asec_q    <= 16'd0;
         running_q <= 1'b0;
         alarm_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         presc_q   <= presc_d;
         asec_q    <= asec_d;
         running_q <= running_d;
         alarm_q   <= alarm_d;
      end
   end

`ifdef TIMER_ALARM_BLINK_EN
   // Ticks counted towards the next alarm blink toggle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         blink_cnt_q <= 8'd0;
      end else begin
         blink_cnt_q <= blink_cnt_d;
      end
   end
`endif

   // Seconds never carry into minutes; minutes wrap 99 -> 00 on their own.
   bcd_digit_counter u_sec_ones (
      .clk(clk), .reset(reset), .clr(dig_clr), .inc(sec_inc), .dec(sec_dec),
      .max_val(DIGIT_MAX), .value(sec_ones), .carry(so_carry), .borrow(so_borrow)
   );
   bcd_digit_counter u_sec_tens (
      .clk(clk), .reset(reset), .clr(dig_clr), .inc(so_carry), .dec(so_borrow),
      .max_val(SEC_TENS_MAX), .value(sec_tens), .carry(unused_st_carry), .borrow(st_borrow)
   );
   bcd_digit_counter u_min_ones (
      .clk(clk), .reset(reset), .clr(dig_clr), .inc(min_inc), .dec(st_borrow),
      .max_val(ones_of(MIN_MAX)), .value(min_ones), .carry(mo_carry), .borrow(mo_borrow)
   );
   bcd_digit_counter u_min_tens (
      .clk(clk), .reset(reset), .clr(dig_clr), .inc(mo_carry), .dec(mo_borrow),
      .max_val(tens_of(MIN_MAX)), .value(min_tens), .carry(unused_mt_carry), .borrow(unused_mt_borrow)
   );

   assign running = running_q;
   assign alarm   = alarm_q;

endmodule

// File: tb/tb_countdown_timer.sv
// Scoreboard bench for countdown_timer: directed scenarios plus random pulses
// checked every cycle against a minutes/seconds reference model.
module tb_countdown_timer;

   localparam int TPS   = 10;
   localparam int ASECS = 30;
   localparam int HALF  = (TPS / 2 < 1) ? 1 : TPS / 2;
   localparam int S_IDLE = 0, S_RUN = 1, S_PAUSE = 2, S_ALARM = 3;

   logic clk = 1'b0, reset = 1'b0;
   logic tick = 1'b0, start = 1'b0, pause = 1'b0, clear = 1'b0;
   logic inc_min = 1'b0, inc_sec = 1'b0;
   logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
   logic running, alarm;

   countdown_timer #(.TICKS_PER_SEC(TPS), .ALARM_SECS(ASECS)) dut (
      .clk(clk), .reset(reset), .tick(tick), .start(start), .pause(pause),
      .clear(clear), .inc_min(inc_min), .inc_sec(inc_sec),
      .min_tens(min_tens), .min_ones(min_ones), .sec_tens(sec_tens),
      .sec_ones(sec_ones), .running(running), .alarm(alarm)
   );

   always #5 clk = ~clk;

   logic [17:0] exp_q[$];
   string       name_q[$];
   int          checks = 0;
   int          failures = 0;
   event        chk_ev;

   int m_state, m_min, m_sec, m_presc, m_aticks;

   function automatic logic [17:0] model_out();
      logic a;
      a = 1'b0;
      if (m_state == S_ALARM) begin
`ifdef TIMER_ALARM_BLINK_EN
         a = (((m_aticks / HALF) % 2) == 0);
`else
         a = 1'b1;
`endif
      end
      return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10),
              (m_state == S_RUN), a};
   endfunction

   task automatic model_idle();
      m_state = S_IDLE; m_min = 0; m_sec = 0; m_presc = TPS - 1; m_aticks = 0;
   endtask

   // Monitor: compare DUT outputs with the oldest expectation.
   always begin
      logic [17:0] e, act;
      string nm;
      @(posedge clk or chk_ev);
      #1;
      if (exp_q.size() > 0) begin
         e   = exp_q.pop_front();
         nm  = name_q.pop_front();
         act = {min_tens, min_ones, sec_tens, sec_ones, running, alarm};
         checks++;
         if (act !== e) begin
            failures++;
            $display("FAIL %s: got mm:ss=%h%h:%h%h run=%b alm=%b, want mm:ss=%h%h:%h%h run=%b alm=%b",
                     nm, act[17:14], act[13:10], act[9:6], act[5:2], act[1], act[0],
                     e[17:14], e[13:10], e[9:6], e[5:2], e[1], e[0]);
         end
      end
   end

   task automatic step(input bit t, input bit c, input bit p, input bit s,
                       input bit im, input bit is, input string nm);
      @(negedge clk);
      tick = t; clear = c; pause = p; start = s; inc_min = im; inc_sec = is;
      case (m_state)
         S_IDLE: begin
            if (c) model_idle();
            else if (p) begin end
            else if (s) begin
               if (m_min != 0 || m_sec != 0) begin m_state = S_RUN; m_presc = TPS - 1; end
            end else begin
               if (im) m_min = (m_min + 1) % 100;
               if (is) m_sec = (m_sec + 1) % 60;
            end
         end
         S_RUN: begin
            if (c) model_idle();
            else if (p) m_state = S_PAUSE;
            else if (t) begin
               if (m_presc == 0) begin
                  m_presc = TPS - 1;
                  if (m_sec > 0) m_sec--;
                  else begin m_min--; m_sec = 59; end
                  if (m_min == 0 && m_sec == 0) begin m_state = S_ALARM; m_aticks = 0; end
               end else m_presc--;
            end
         end
         S_PAUSE: begin
            if (c) model_idle();
            else if (p) begin end
            else if (s) m_state = S_RUN;
         end
         default: begin
            if (c || (s && !p)) model_idle();
            else if (t) begin
               m_aticks++;
               if (m_aticks == ASECS * TPS) model_idle();
            end
         end
      endcase
      exp_q.push_back(model_out());
      name_q.push_back(nm);
   endtask

   task automatic idle(input int n, input string nm);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, nm);
   endtask

   task automatic ticks(input int n, input string nm);
      for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 0, nm);
   endtask

   task automatic do_reset(input string nm);
      @(negedge clk);
      tick = 0; clear = 0; pause = 0; start = 0; inc_min = 0; inc_sec = 0;
      #2;
      reset = 1'b1;
      model_idle();
      exp_q.push_back(model_out());
      name_q.push_back(nm);
      -> chk_ev;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      bit c, p, s, im, is;
      int r;
      model_idle();
      do_reset("reset_initial");
      idle(2, "reset_hold");

      // 00:03 countdown into ALARM
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0, 1, "inc_sec_x3");
      step(0, 0, 0, 1, 0, 0, "start_003");
      ticks(30, "count_003");
      idle(3, "alarm_steady");
      checks++;
      if (alarm !== 1'b1 || running !== 1'b0) begin
         failures++;
         $display("FAIL alarm_direct: alarm=%b running=%b", alarm, running);
      end
      step(0, 0, 0, 1, 0, 0, "alarm_ack");

      // seconds wrap without carry, minutes wrap, both increments together
      for (int i = 0; i < 59; i++) step(0, 0, 0, 0, 0, 1, "set_0059");
      step(0, 0, 0, 0, 0, 1, "sec_wrap");
      for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0, 1, "set_sec7");
      for (int i = 0; i < 99; i++) step(0, 0, 0, 0, 1, 0, "set_min99");
      step(0, 0, 0, 0, 1, 0, "min_wrap");
      step(0, 0, 0, 0, 1, 1, "inc_both");
      step(0, 1, 0, 0, 0, 0, "clear_idle");
      step(0, 0, 0, 1, 0, 0, "start_zero_ignored");

      // 01:00 borrow and inc during RUN
      step(0, 0, 0, 0, 1, 0, "set_0100");
      step(0, 0, 0, 1, 0, 0, "start_0100");
      ticks(10, "borrow_0059");
      step(0, 0, 0, 0, 1, 0, "inc_min_in_run");
      step(0, 0, 0, 0, 0, 1, "inc_sec_in_run");
      step(0, 1, 0, 0, 0, 0, "clear_run");

      // pause retains prescaler
      for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0, 1, "set_0005");
      step(0, 0, 0, 1, 0, 0, "start_0005");
      ticks(4, "pre_pause");
      step(0, 0, 1, 0, 0, 0, "pause");
      ticks(20, "ticks_in_pause");
      step(0, 0, 0, 1, 0, 0, "resume");
      ticks(6, "post_resume");
      idle(2, "after_0004");

      // clear with simultaneous tick, then async reset mid-RUN
      step(1, 1, 0, 0, 0, 0, "clear_with_tick");
      for (int i = 0; i < 2; i++) step(0, 0, 0, 0, 1, 0, "set_0200");
      step(0, 0, 0, 1, 0, 0, "start_0200");
      ticks(13, "run_0200");
      do_reset("reset_mid_run");
      idle(2, "after_reset");
      checks++;
      if ({min_tens, min_ones, sec_tens, sec_ones} !== 16'h0000 || running !== 1'b0 || alarm !== 1'b0) begin
         failures++;
         $display("FAIL reset_direct: mm:ss=%h%h:%h%h run=%b alm=%b",
                  min_tens, min_ones, sec_tens, sec_ones, running, alarm);
      end

      // ALARM auto-return after ALARM_SECS seconds of ticks
      step(0, 0, 0, 0, 0, 1, "set_0001");
      step(0, 0, 0, 1, 0, 0, "start_0001");
      ticks(10, "reach_alarm");
      for (int i = 0; i < ASECS * TPS; i++) begin
         step(1, 0, 0, 0, 0, 0, "alarm_timeout");
         step(0, 0, 0, 0, 0, 0, "alarm_timeout_gap");
      end
      idle(2, "after_timeout");

      // random pulses
      for (int i = 0; i < 4000; i++) begin
         if (i == 2000) do_reset("reset_random");
         r = $urandom_range(0, 255);
         c = 0; p = 0; s = 0; im = 0; is = 0;
         if (r < 3) c = 1;
         else if (r < 12) p = 1;
         else if (r < 32) s = 1;
         else if (r < 38) im = 1;
         else if (r < 70) is = 1;
         else if (r < 73) begin im = 1; is = 1; end
         step(1'($urandom_range(0, 1)), c, p, s, im, is, "random");
      end
      idle(3, "drain");
      @(negedge clk);
      if (failures == 0 && checks > 0) $display("PASS all checks");
      else $display("FAIL summary: %0d failures in %0d checks", failures, checks);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
